nl2_dbank_rmw_wr_ctrl: RTL

//  Data-bank write controller at the far end of the buffer write channel (wdata_out_*/wdata_out_accept/wdata_rmw_read).

---
 rtl/nl2_dbank_rmw_wr_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/nl2_dbank_rmw_wr_ctrl.sv
// Data-bank write controller: SRAM writes, partial-segment read-modify-write and post-reset zero-init sweep.
// Write strobe one cycle after a word is seen in IDLE; the buffer is held off (no accept) until the write cycle.
module nl2_dbank_rmw_wr_ctrl #(
    parameter int N_SRAM         = 4,
    parameter int N_NARROW       = 4,
    parameter int BNK_ADDR_SIZE  = 10,
    parameter int BNK_DATA_WIDTH = 8,
    parameter int BNK_ECC_WIDTH  = 4,
    parameter int RAW_MASK_W     = 2,
    parameter int SRAM_RD_LAT    = 2,
    parameter int RMW_ECC_PIPE   = 1
) (
    input  logic                                    dbank_ctrl_clk,
    input  logic                                    rst_a,
    input  logic                                    init_req,
    output logic                                    init_going,
    output logic                                    init_done,
    input  logic                                    rd_busy,
    input  logic [BNK_ADDR_SIZE-1:0]                wr_addr,
    input  logic [N_SRAM-1:0]                       wr_sram_sel,
    input  logic                                    wdata_out_valid,
    input  logic                                    wdata_out_rmw_req,
    input  logic                                    wdata_out_err,
    input  logic [BNK_DATA_WIDTH-1:0]               wdata_out_data,
    input  logic [BNK_ECC_WIDTH-1:0]                wdata_out_ecc,
    input  logic [RAW_MASK_W*N_NARROW-1:0]          wdata_out_mask,
    output logic                                    wdata_out_accept,
    output logic                                    wdata_rmw_read,
    output logic [N_SRAM-1:0]                       sram_me,
    output logic                                    sram_we,
    output logic [BNK_ADDR_SIZE-1:0]                sram_addr,
    output logic [BNK_DATA_WIDTH+BNK_ECC_WIDTH-1:0] sram_wdata,
    output logic [RAW_MASK_W*N_NARROW-1:0]          sram_wmask,
    output logic                                    wr_done,
    output logic                                    wr_err,
    output logic                                    idle
);

    localparam int MASK_W = RAW_MASK_W * N_NARROW;
    localparam int WD_W   = BNK_DATA_WIDTH + BNK_ECC_WIDTH;
    localparam int LAT_W  = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WR,
        S_RMW_RD,
        S_RMW_WAIT,
        S_RMW_MRG
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [BNK_ADDR_SIZE-1:0] lat_addr;
    logic [N_SRAM-1:0]        lat_sel;
    logic [LAT_W-1:0]         lat_cnt;
    logic [1:0]               mrg_cnt;
    logic [BNK_ADDR_SIZE-1:0] init_cnt;
    logic                     rmw_pend;
    logic [BNK_ADDR_SIZE-1:0] addr_q;
    logic [WD_W-1:0]          wdata_q;
    logic [MASK_W-1:0]        wmask_q;
    logic                     init_last;
    logic                     take_word;

    assign init_last = (init_cnt == {BNK_ADDR_SIZE{1'b1}});
    assign take_word = (state == S_IDLE) && !rd_busy && !init_req && wdata_out_valid;

    always_ff @(posedge dbank_ctrl_clk or posedge rst_a) begin
        if (rst_a) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_sel   <= '0;
            lat_cnt   <= '0;
            mrg_cnt   <= '0;
            init_cnt  <= '0;
            rmw_pend  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state == S_INIT) && init_last;
            if (take_word) begin
                lat_addr <= wr_addr;
                lat_sel  <= wr_sram_sel;
            end
            if (state == S_RMW_RD) begin
                lat_cnt <= LAT_W'(SRAM_RD_LAT - 1);
            end else if (state == S_RMW_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (state == S_RMW_WAIT && lat_cnt == '0) begin
                mrg_cnt <= 2'(RMW_ECC_PIPE + 1);
            end else if (state == S_RMW_MRG && mrg_cnt != 2'd0) begin
                mrg_cnt <= mrg_cnt - 2'd1;
            end
            if (state == S_INIT) begin
                init_cnt <= init_last ? '0 : init_cnt + BNK_ADDR_SIZE'(1);
            end
            if (state == S_RMW_RD) begin
                rmw_pend <= 1'b1;
            end else if (state == S_WR) begin
                rmw_pend <= 1'b0;
            end
            // Hold the address/data/mask pins between accesses so they never toggle idly.
            if (|sram_me) begin
                addr_q  <= sram_addr;
                wdata_q <= sram_wdata;
                wmask_q <= sram_wmask;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        sram_me          = '0;
        sram_we          = 1'b0;
        sram_addr        = addr_q;
        sram_wdata       = wdata_q;
        sram_wmask       = wmask_q;
        wdata_out_accept = 1'b0;
        wdata_rmw_read   = 1'b0;
        wr_done          = 1'b0;
        wr_err           = 1'b0;
        init_going       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rd_busy) begin
                    if (init_req) begin
                        state_nxt = S_INIT;
                    end else if (wdata_out_valid) begin
                        state_nxt = wdata_out_rmw_req ? S_RMW_RD : S_WR;
                    end
                end
            end
            S_INIT: begin
                init_going = 1'b1;
                sram_me    = '1;
                sram_we    = 1'b1;
                sram_addr  = init_cnt;
                sram_wdata = {wdata_out_ecc, {BNK_DATA_WIDTH{1'b0}}};
                sram_wmask = '1;
                if (init_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                // A merge that still asks for RMW is retried from the read rather than written.
                if (rmw_pend && wdata_out_rmw_req) begin
                    state_nxt = S_RMW_RD;
                end else begin
                    sram_me          = lat_sel;
                    sram_we          = 1'b1;
                    sram_addr        = lat_addr;
                    sram_wdata       = {wdata_out_ecc, wdata_out_data};
                    sram_wmask       = wdata_out_mask;
                    wdata_out_accept = 1'b1;
                    wr_done          = 1'b1;
                    wr_err           = wdata_out_err;
                    state_nxt        = S_IDLE;
                end
            end
            S_RMW_RD: begin
                sram_me   = lat_sel;
                sram_addr = lat_addr;
                state_nxt = S_RMW_WAIT;
            end
            S_RMW_WAIT: begin
                if (lat_cnt == '0) begin
                    wdata_rmw_read = 1'b1;
                    state_nxt      = S_RMW_MRG;
                end
            end
            S_RMW_MRG: begin
                // The write cycle coincides with the merge counter reaching zero.
                if (mrg_cnt == 2'd1) begin
                    state_nxt = S_WR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign idle = (state == S_IDLE) && !wdata_out_valid && !rst_a;

    assert property (@(posedge dbank_ctrl_clk) disable iff (rst_a)
        !(wdata_rmw_read && rd_busy));
    assert property (@(posedge dbank_ctrl_clk) disable iff (rst_a)
        !(state == S_WR && rmw_pend && wdata_out_rmw_req));

endmodule
